sound_latch: RTL and testbench

Bidirectional command mailbox between the main 68000 and the sound 68000. It sits directly downstream of the address decoder and consumes its latch chip selects: main-CPU writes to latch0 go to the sound CPU with an interrupt, and sound-CPU writes to latch1 come back to the main CPU. It qualifies the decoder's unstrobed selects with AS/RW so that each bus cycle produces exactly one push or pop.

---
 rtl/megasys1_pkg.sv | 14 +
 rtl/latch_fifo.sv | 90 +++++++++
 rtl/sound_latch.sv | 117 +++++++++++
 tb/tb_sound_latch.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/megasys1_pkg.sv
//------------------------------------------------------------------------------
// megasys1_pkg
// Shared sizing constants for the main/sound CPU mailbox.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package megasys1_pkg;
    localparam int LATCH_DW         = 16;
    localparam int LATCH_FIFO_DEPTH = 4;
    localparam int LATCH_PTR_W      = 2;
endpackage

`default_nettype wire

// File: rtl/latch_fifo.sv
//------------------------------------------------------------------------------
// latch_fifo
// Command storage with push/pop, head and empty; DEPTH=1 gives a pending latch.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module latch_fifo
    import megasys1_pkg::*;
#(
    parameter int DEPTH     = LATCH_FIFO_DEPTH,
    parameter int PTR_W     = LATCH_PTR_W,
    parameter int DW        = LATCH_DW,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output logic          empty,
    output logic          overflow
);

    localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_overflow;

    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_clobber;
    logic [PTR_W-1:0] w_wr_next;
    logic [PTR_W-1:0] w_rd_next;
    logic [PTR_W-1:0] w_newest;

    assign empty     = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    // A pop frees a slot in the same cycle, so a push to a full queue with a pop is kept.
    assign w_pop     = pop & ~empty;
    assign w_push    = push & (~w_full | w_pop);
    assign w_drop    = push & w_full & ~w_pop;
    assign w_clobber = w_drop & OVERWRITE;

    assign w_wr_next = (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_next = (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
    assign w_newest  = (r_wr_ptr == '0) ? LAST : r_wr_ptr - 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem      <= '{default: '0};
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= w_wr_next;
            end
            if (w_clobber) begin
                r_mem[w_newest] <= din;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head     = r_mem[r_rd_ptr];
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/sound_latch.sv
//------------------------------------------------------------------------------
// sound_latch
// Main/sound 68000 command and reply mailbox. SOUND_LATCH_FIFO_EN selects a
// 4-entry command FIFO instead of a single overwriting latch.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sound_latch
    import megasys1_pkg::*;
#(
    parameter int DW = LATCH_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m68kp_latch0_cs,
    input  logic          m68kp_latch1_cs,
    input  logic          m68kp_as_n,
    input  logic          m68kp_rw,
    input  logic [DW-1:0] m68kp_din,
    output logic [DW-1:0] m68kp_latch_dout,
    output logic          m68kp_reply_pending,
    input  logic          m68ks_latch0_cs,
    input  logic          m68ks_latch1_cs,
    input  logic          m68ks_as_n,
    input  logic          m68ks_rw,
    input  logic [DW-1:0] m68ks_din,
    output logic [DW-1:0] m68ks_latch_dout,
    output logic          snd_irq_n,
    output logic          cmd_overflow
);

    logic          w_mw, w_mr, w_sw, w_sr;
    logic          r_mw, r_mr, r_sw, r_sr;
    logic          w_mw_ev, w_mr_ev, w_sw_ev, w_sr_ev;
    logic [DW-1:0] r_reply;
    logic          r_reply_pending;
    logic          w_cmd_empty;

    assign w_mw = m68kp_latch0_cs & ~m68kp_rw & ~m68kp_as_n;
    assign w_mr = m68kp_latch1_cs &  m68kp_rw & ~m68kp_as_n;
    assign w_sw = m68ks_latch1_cs & ~m68ks_rw & ~m68ks_as_n;
    assign w_sr = m68ks_latch0_cs &  m68ks_rw & ~m68ks_as_n;

    // Preset to 1 so a strobe already high when reset releases cannot fire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mw <= 1'b1;
            r_mr <= 1'b1;
            r_sw <= 1'b1;
            r_sr <= 1'b1;
        end else begin
            r_mw <= w_mw;
            r_mr <= w_mr;
            r_sw <= w_sw;
            r_sr <= w_sr;
        end
    end

    assign w_mw_ev = w_mw & ~r_mw;
    assign w_mr_ev = w_mr & ~r_mr;
    assign w_sw_ev = w_sw & ~r_sw;
    assign w_sr_ev = w_sr & ~r_sr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reply         <= '0;
            r_reply_pending <= 1'b0;
        end else if (w_sw_ev) begin
            r_reply         <= m68ks_din;
            r_reply_pending <= 1'b1;
        end else if (w_mr_ev) begin
            r_reply_pending <= 1'b0;
        end
    end

`ifdef SOUND_LATCH_FIFO_EN
    latch_fifo #(
        .DEPTH     (LATCH_FIFO_DEPTH),
        .PTR_W     (LATCH_PTR_W),
        .DW        (DW),
        .OVERWRITE (1'b0)
    ) u_cmd (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (w_mw_ev),
        .pop      (w_sr_ev),
        .din      (m68kp_din),
        .head     (m68ks_latch_dout),
        .empty    (w_cmd_empty),
        .overflow (cmd_overflow)
    );
`else
    latch_fifo #(
        .DEPTH     (1),
        .PTR_W     (1),
        .DW        (DW),
        .OVERWRITE (1'b1)
    ) u_cmd (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (w_mw_ev),
        .pop      (w_sr_ev),
        .din      (m68kp_din),
        .head     (m68ks_latch_dout),
        .empty    (w_cmd_empty),
        .overflow (cmd_overflow)
    );
`endif

    assign snd_irq_n           = w_cmd_empty;
    assign m68kp_latch_dout    = r_reply;
    assign m68kp_reply_pending = r_reply_pending;

endmodule

`default_nettype wire

// File: tb/tb_sound_latch.sv
//------------------------------------------------------------------------------
// tb_sound_latch
// Directed self-checking bench for sound_latch (both SOUND_LATCH_FIFO_EN builds).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sound_latch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_cs, m1_cs, m_as_n, m_rw;
    logic [15:0] m_din;
    logic [15:0] p_dout;
    logic        p_pending;
    logic        s0_cs, s1_cs, s_as_n, s_rw;
    logic [15:0] s_din;
    logic [15:0] s_dout;
    logic        irq_n;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sound_latch #(.DW(16)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .m68kp_latch0_cs     (m0_cs),
        .m68kp_latch1_cs     (m1_cs),
        .m68kp_as_n          (m_as_n),
        .m68kp_rw            (m_rw),
        .m68kp_din           (m_din),
        .m68kp_latch_dout    (p_dout),
        .m68kp_reply_pending (p_pending),
        .m68ks_latch0_cs     (s0_cs),
        .m68ks_latch1_cs     (s1_cs),
        .m68ks_as_n          (s_as_n),
        .m68ks_rw            (s_rw),
        .m68ks_din           (s_din),
        .m68ks_latch_dout    (s_dout),
        .snd_irq_n           (irq_n),
        .cmd_overflow        (ovf)
    );

    task automatic idle_main;
        m0_cs = 1'b0; m1_cs = 1'b0; m_as_n = 1'b1; m_rw = 1'b1;
    endtask

    task automatic idle_snd;
        s0_cs = 1'b0; s1_cs = 1'b0; s_as_n = 1'b1; s_rw = 1'b1;
    endtask

    task automatic drive_mw(input logic [15:0] d);
        m0_cs = 1'b1; m_rw = 1'b0; m_as_n = 1'b0; m_din = d;
    endtask

    task automatic drive_mr;
        m1_cs = 1'b1; m_rw = 1'b1; m_as_n = 1'b0;
    endtask

    task automatic drive_sw(input logic [15:0] d);
        s1_cs = 1'b1; s_rw = 1'b0; s_as_n = 1'b0; s_din = d;
    endtask

    task automatic drive_sr;
        s0_cs = 1'b1; s_rw = 1'b1; s_as_n = 1'b0;
    endtask

    // One-clock bus cycles; each returns on the negedge after the sampling edge.
    task automatic main_write(input logic [15:0] d);
        @(negedge clk); drive_mw(d);
        @(negedge clk); idle_main();
    endtask

    task automatic main_read;
        @(negedge clk); drive_mr();
        @(negedge clk); idle_main();
    endtask

    task automatic snd_write(input logic [15:0] d);
        @(negedge clk); drive_sw(d);
        @(negedge clk); idle_snd();
    endtask

    task automatic snd_read;
        @(negedge clk); drive_sr();
        @(negedge clk); idle_snd();
    endtask

    task automatic test_reset;
        checks++; if (p_dout !== 16'h0000) begin errors++; $display("FAIL reset_p_dout got %h want 0000", p_dout); end
        checks++; if (s_dout !== 16'h0000) begin errors++; $display("FAIL reset_s_dout got %h want 0000", s_dout); end
        checks++; if (p_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", p_pending); end
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL reset_irq_n got %b want 1", irq_n); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    endtask

    task automatic test_cmd_write;
        @(negedge clk); drive_mw(16'h00A5);
        #1;
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL cmd_irq_early got %b want 1", irq_n); end
        @(negedge clk); idle_main();
        checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL cmd_irq got %b want 0", irq_n); end
        checks++; if (s_dout !== 16'h00A5) begin errors++; $display("FAIL cmd_data got %h want 00a5", s_dout); end
        snd_read();
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL cmd_irq_clear got %b want 1", irq_n); end
    endtask

    task automatic test_hold;
        @(negedge clk); drive_mw(16'h0042);
        repeat (6) @(negedge clk);
        idle_main();
        checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL hold_irq got %b want 0", irq_n); end
        checks++; if (s_dout !== 16'h0042) begin errors++; $display("FAIL hold_data got %h want 0042", s_dout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL hold_ovf got %b want 0", ovf); end
        snd_read();
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL hold_single_push got irq %b want 1", irq_n); end
        snd_read();
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL empty_pop got irq %b want 1", irq_n); end
    endtask

    task automatic test_reply;
        snd_write(16'h1234);
        checks++; if (p_pending !== 1'b1) begin errors++; $display("FAIL reply_pending got %b want 1", p_pending); end
        checks++; if (p_dout !== 16'h1234) begin errors++; $display("FAIL reply_data got %h want 1234", p_dout); end
        main_read();
        checks++; if (p_pending !== 1'b0) begin errors++; $display("FAIL reply_clear got %b want 0", p_pending); end
        checks++; if (p_dout !== 16'h1234) begin errors++; $display("FAIL reply_retain got %h want 1234", p_dout); end
    endtask

    task automatic test_reply_simul;
        @(negedge clk); drive_sw(16'h5678); drive_mr();
        @(negedge clk); idle_snd(); idle_main();
        checks++; if (p_pending !== 1'b1) begin errors++; $display("FAIL simul_pending got %b want 1", p_pending); end
        checks++; if (p_dout !== 16'h5678) begin errors++; $display("FAIL simul_data got %h want 5678", p_dout); end
        main_read();
        checks++; if (p_pending !== 1'b0) begin errors++; $display("FAIL simul_clear got %b want 0", p_pending); end
    endtask

    task automatic test_back_to_back;
        main_write(16'h0011);
        @(negedge clk); drive_mw(16'h0022); drive_sr();
        @(negedge clk); idle_main(); idle_snd();
        checks++; if (s_dout !== 16'h0022) begin errors++; $display("FAIL b2b_head got %h want 0022", s_dout); end
        checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL b2b_irq got %b want 0", irq_n); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b want 0", ovf); end
        snd_read();
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL b2b_count got irq %b want 1", irq_n); end
    endtask

`ifdef SOUND_LATCH_FIFO_EN
    task automatic test_fifo;
        for (int i = 1; i <= 5; i++) main_write(16'(i));
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL fifo_ovf got %b want 1", ovf); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (s_dout !== 16'(i)) begin errors++; $display("FAIL fifo_head%0d got %h want %h", i, s_dout, 16'(i)); end
            checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL fifo_irq%0d got %b want 0", i, irq_n); end
            snd_read();
        end
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL fifo_drained got irq %b want 1", irq_n); end
    endtask
`else
    task automatic test_overwrite;
        main_write(16'h0001);
        main_write(16'h0002);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovw_ovf got %b want 1", ovf); end
        checks++; if (s_dout !== 16'h0002) begin errors++; $display("FAIL ovw_data got %h want 0002", s_dout); end
        checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL ovw_irq got %b want 0", irq_n); end
        snd_read();
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL ovw_pop got irq %b want 1", irq_n); end
    endtask
`endif

    task automatic test_reset_mid;
        main_write(16'h0101);
        main_write(16'h0202);
        snd_write(16'h3333);
        @(negedge clk); drive_mw(16'h0777);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL rst_held_irq got %b want 1", irq_n); end
        checks++; if (s_dout !== 16'h0000) begin errors++; $display("FAIL rst_held_data got %h want 0000", s_dout); end
        m_as_n = 1'b1;
        @(negedge clk); m_as_n = 1'b0;
        @(negedge clk); idle_main();
        checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL rst_refire_irq got %b want 0", irq_n); end
        checks++; if (s_dout !== 16'h0777) begin errors++; $display("FAIL rst_refire_data got %h want 0777", s_dout); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        m_din = '0;
        s_din = '0;
        idle_main();
        idle_snd();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_cmd_write();
        test_hold();
        test_reply();
        test_reply_simul();
        test_back_to_back();
`ifdef SOUND_LATCH_FIFO_EN
        test_fifo();
`else
        test_overwrite();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
